// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: state encoding and word-count helper shared by the chain loader
package ccff_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  function automatic int num_words(input int len, input int w);
    return (len + w - 1) / w;
  endfunction
endpackage

// File: rtl/ccff_rb_deserializer.sv
// ccff_rb_deserializer: gathers chain tail bits into LSB-first readback words
module ccff_rb_deserializer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              shift_en,
  input  logic              tail,
  input  logic              last,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);
  localparam int IW = WORD_W > 1 ? $clog2(WORD_W) : 1;
  logic [WORD_W-1:0] rb, rb_nxt;
  logic [IW-1:0] rb_idx;
  logic flush;
  always_comb begin
    rb_nxt = rb;
    rb_nxt[rb_idx] = tail;
  end
  assign flush = shift_en && (last || rb_idx == IW'(WORD_W - 1));
  // rb is cleared after every flush so a short final word comes out zero-padded
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rb <= '0;
      rb_idx <= '0;
      rb_data <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= flush;
      if (start) begin
        rb <= '0;
        rb_idx <= '0;
      end else if (flush) begin
        rb <= '0;
        rb_idx <= '0;
        rb_data <= rb_nxt;
      end else if (shift_en) begin
        rb <= rb_nxt;
        rb_idx <= rb_idx + IW'(1);
      end
    end
endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams config words LSB-first into a DFF chain and reads back the displaced bits
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              chain_head,
  output logic              chain_shift_en,
  input  logic              chain_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);
  localparam int NUM_WORDS = num_words(CHAIN_LEN, WORD_W);
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W = $clog2(WORD_W + 1);
  localparam int WC_W = $clog2(NUM_WORDS + 1);
  state_t state, state_nxt;
  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [WB_W-1:0] word_bit;
  logic [WC_W-1:0] word_cnt;
  logic start_ok, shifting, last_bit, word_end, accept;
  assign start_ok = start && (state == IDLE || state == DONE);
  assign shifting = state == SHIFT;
  assign last_bit = shifting && bit_cnt == CNT_W'(CHAIN_LEN - 1);
  assign word_end = shifting && word_bit == WB_W'(WORD_W - 1);
  assign word_ready = state == LOAD || (word_end && word_cnt != WC_W'(NUM_WORDS));
  assign accept = word_ready && word_valid;
  assign busy = state == LOAD || shifting;
  assign done = state == DONE;
  assign chain_shift_en = shifting;
  assign chain_head = shifting && shreg[0];
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  // a word boundary with no word on offer parks in LOAD, holding the chain
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = start ? LOAD : IDLE;
      LOAD:  state_nxt = word_valid ? SHIFT : LOAD;
      SHIFT: state_nxt = last_bit ? DONE : !word_end ? SHIFT : accept ? SHIFT : LOAD;
      DONE:  state_nxt = start ? LOAD : DONE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      shreg <= '0;
      bit_cnt <= '0;
      word_bit <= '0;
      word_cnt <= '0;
    end else begin
      shreg <= accept ? word_data : shifting ? shreg >> 1 : shreg;
      bit_cnt <= start_ok ? '0 : shifting ? bit_cnt + CNT_W'(1) : bit_cnt;
      word_bit <= accept ? '0 : shifting ? word_bit + WB_W'(1) : word_bit;
      word_cnt <= start_ok ? '0 : accept ? word_cnt + WC_W'(1) : word_cnt;
    end
  ccff_rb_deserializer #(.WORD_W(WORD_W)) u_rb (
    .clk(clk),
    .reset(reset),
    .start(start_ok),
    .shift_en(shifting),
    .tail(chain_tail),
    .last(last_bit),
    .rb_data(rb_data),
    .rb_valid(rb_valid)
  );
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: vector-table, random and corner-case checks of the loader against a DFF chain model
module tb_ccff_chain_loader;
  localparam int L = 10;
  localparam int W = 4;
  localparam int N = 3;
  typedef struct {
    logic [N*W-1:0] ws;
    int gap;
    bit poke;
    logic [L-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic word_valid = 1'b0;
  logic [W-1:0] word_data = '0;
  logic word_ready, chain_head, chain_shift_en, chain_tail, rb_valid, busy, done;
  logic [W-1:0] rb_data;

  logic start2 = 1'b0;
  logic valid2 = 1'b0;
  logic [7:0] data_b = 8'h81;
  logic [7:0] data_c = 8'hFD;
  logic ready_b, head_b, sen_b, tail_b, rbv_b, busy_b, done_b;
  logic ready_c, head_c, sen_c, tail_c, rbv_c, busy_c, done_c;
  logic [7:0] rb_b, rb_c;

  logic [L-1:0] chain;
  logic [7:0] chain_b;
  logic [2:0] chain_c;
  logic pre_en = 1'b0;
  logic [L-1:0] pre_val = '0;
  logic [L-1:0] prev;

  int checks = 0;
  int errors = 0;
  int shifts = 0, busy_n = 0, ldc = 0, rb_n = 0;
  int sh_b = 0, sh_c = 0, rbn_b = 0, rbn_c = 0;
  logic [W-1:0] rb_log [0:255];
  logic [7:0] last_b = '0, last_c = '0;

  always #5 clk = ~clk;

  ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .word_data(word_data), .word_valid(word_valid),
    .word_ready(word_ready), .chain_head(chain_head), .chain_shift_en(chain_shift_en),
    .chain_tail(chain_tail), .rb_data(rb_data), .rb_valid(rb_valid), .busy(busy), .done(done)
  );
  ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8)) dut_b (
    .clk(clk), .reset(reset), .start(start2), .word_data(data_b), .word_valid(valid2),
    .word_ready(ready_b), .chain_head(head_b), .chain_shift_en(sen_b),
    .chain_tail(tail_b), .rb_data(rb_b), .rb_valid(rbv_b), .busy(busy_b), .done(done_b)
  );
  ccff_chain_loader #(.CHAIN_LEN(3), .WORD_W(8)) dut_c (
    .clk(clk), .reset(reset), .start(start2), .word_data(data_c), .word_valid(valid2),
    .word_ready(ready_c), .chain_head(head_c), .chain_shift_en(sen_c),
    .chain_tail(tail_c), .rb_data(rb_c), .rb_valid(rbv_c), .busy(busy_c), .done(done_c)
  );

  // index 0 is the tail flip-flop; new bits enter at the top
  always @(posedge clk) begin
    chain <= pre_en ? pre_val : chain_shift_en ? {chain_head, chain[L-1:1]} : chain;
    chain_b <= pre_en ? 8'h3C : sen_b ? {head_b, chain_b[7:1]} : chain_b;
    chain_c <= pre_en ? 3'b110 : sen_c ? {head_c, chain_c[2:1]} : chain_c;
  end
  assign chain_tail = chain[0];
  assign tail_b = chain_b[0];
  assign tail_c = chain_c[0];

  always @(negedge clk) begin
    if (chain_shift_en) shifts++;
    if (busy) busy_n++;
    if (busy && word_ready && !chain_shift_en) ldc++;
    if (rb_valid) begin
      rb_log[rb_n[7:0]] = rb_data;
      rb_n++;
    end
    if (sen_b) sh_b++;
    if (sen_c) sh_c++;
    if (rbv_b) begin last_b = rb_b; rbn_b++; end
    if (rbv_c) begin last_c = rb_c; rbn_c++; end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!word_ready && n < 40) begin
      tick();
      n++;
    end
    chk({nm, " ready"}, 32'(word_ready), 32'd1);
  endtask

  task automatic run_load(input vec_t v, input string nm);
    int s0, b0, l0, r0, n, idx;
    logic [N*W-1:0] pw;
    s0 = shifts; b0 = busy_n; l0 = ldc; r0 = rb_n;
    pw = 12'(prev);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (k == 1 && v.gap > 0) begin
        word_valid = 1'b0;
        wait_ready(nm);
        for (int g = 0; g < v.gap; g++) tick();
      end
      word_data = v.ws[k*W +: W];
      word_valid = 1'b1;
      if (k == 1 && v.poke) start = 1'b1;
      wait_ready(nm);
      tick();
      start = 1'b0;
    end
    word_valid = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    tick();
    chk({nm, " done"}, 32'(done), 32'd1);
    chk({nm, " chain"}, 32'(chain), 32'(v.exp));
    chk({nm, " shifts"}, shifts - s0, L);
    chk({nm, " busy cycles"}, busy_n - b0, 1 + L + v.gap);
    chk({nm, " starved cycles"}, ldc - l0, 1 + v.gap);
    chk({nm, " rb count"}, rb_n - r0, N);
    for (int k = 0; k < N; k++) begin
      idx = r0 + k;
      chk($sformatf("%s rb%0d", nm, k), 32'(rb_log[idx[7:0]]), 32'(pw[k*W +: W]));
    end
    prev = v.exp;
  endtask

  vec_t vecs [6];
  vec_t rv;
  int s0;

  initial begin
    vecs[0] = '{12'h35A, 0, 1'b0, 10'h35A};
    vecs[1] = '{12'h35A, 5, 1'b0, 10'h35A};
    vecs[2] = '{12'hFFF, 0, 1'b1, 10'h3FF};
    vecs[3] = '{12'hC00, 2, 1'b0, 10'h000};
    vecs[4] = '{12'h2C7, 1, 1'b1, 10'h2C7};
    vecs[5] = '{12'h5A5, 3, 1'b0, 10'h1A5};
    pre_val = 10'h2C7;
    prev = 10'h2C7;
    pre_en = 1'b1;
    tick();
    tick();
    pre_en = 1'b0;
    chk("reset outputs", 32'({word_ready, chain_head, chain_shift_en, rb_valid, busy, done, rb_data}), 32'd0);
    chk("reset b/c", 32'({busy_b, done_b, ready_b, sen_b, busy_c, done_c, ready_c, sen_c}), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle", 32'({busy, done, word_ready}), 32'd0);

    for (int i = 0; i < 6; i++) run_load(vecs[i], $sformatf("vec%0d", i));

    for (int r = 0; r < 6; r++) begin
      rv.ws = 12'($urandom);
      rv.gap = $urandom_range(0, 3);
      rv.poke = 1'($urandom_range(0, 1));
      rv.exp = rv.ws[L-1:0];
      run_load(rv, $sformatf("rnd%0d", r));
    end

    word_data = 4'hF;
    word_valid = 1'b1;
    s0 = shifts;
    tick(); tick(); tick();
    chk("done hold", 32'(done), 32'd1);
    chk("done ready", 32'(word_ready), 32'd0);
    chk("done no shift", shifts - s0, 0);
    word_valid = 1'b0;

    s0 = shifts;
    start = 1'b1;
    tick();
    start = 1'b0;
    word_data = 4'h9;
    word_valid = 1'b1;
    wait_ready("abort");
    tick();
    word_data = 4'h6;
    tick(); tick(); tick(); tick();
    chk("pre-abort", 32'({busy, chain_shift_en}), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("abort outputs", 32'({word_ready, chain_head, chain_shift_en, rb_valid, busy, done, rb_data}), 32'd0);
    chk("abort shifts", shifts - s0, 4);
    prev = (prev >> 4) | (10'(4'h9) << (L - 4));
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("post-abort idle", 32'({busy, done, word_ready}), 32'd0);
    word_valid = 1'b0;
    run_load(vecs[0], "reload");

    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    valid2 = 1'b1;
    chk("bnd ready", 32'({ready_b, ready_c}), 32'd3);
    tick();
    tick(); tick(); tick();
    chk("c done", 32'(done_c), 32'd1);
    chk("c shifts", sh_c, 3);
    chk("c chain", 32'(chain_c), 32'h5);
    chk("c ready in done", 32'(ready_c), 32'd0);
    chk("b still busy", 32'(busy_b), 32'd1);
    tick(); tick(); tick(); tick(); tick();
    chk("b done", 32'(done_b), 32'd1);
    chk("b shifts", sh_b, 8);
    chk("b chain", 32'(chain_b), 32'h81);
    tick();
    valid2 = 1'b0;
    chk("c shifts held", sh_c, 3);
    chk("c rb count", rbn_c, 1);
    chk("c rb data", 32'(last_c), 32'h06);
    chk("b rb count", rbn_b, 1);
    chk("b rb data", 32'(last_b), 32'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
